// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select, HALT state machine and an
// optional retired-instruction counter (enabled by defining MEM_WB_RETIRE_CNT_EN).
module mem_wb_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               en_pipeline,
  input  logic               valid_i,
  input  logic [NB_DATA-1:0] mem_data_i,
  input  logic [NB_DATA-1:0] alu_result_i,
  input  logic [NB_DATA-1:0] pc_plus8_i,
  input  logic [2:0]         wb_signals_i,
  input  logic [NB_REG-1:0]  rd_i,
  input  logic               halt_i,
  output logic [NB_DATA-1:0] wb_data_o,
  output logic [NB_REG-1:0]  wb_rd_o,
  output logic               wb_reg_write_o,
  output logic               halt_o,
  output logic [31:0]        retired_o
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state;
  state_t             state_next;
  logic               advance;
  logic [NB_DATA-1:0] wb_data_sel;
  logic               reg_write_next;

  // Once HALTED the whole stage freezes, so every register shares one enable.
  assign advance        = en_pipeline && (state == RUN);
  assign reg_write_next = wb_signals_i[2] && valid_i && !halt_i && (rd_i != '0);

  always_comb begin
    wb_data_sel = alu_result_i;
    case (wb_signals_i[1:0])
      2'b01:   wb_data_sel = mem_data_i;
      2'b10:   wb_data_sel = pc_plus8_i;
      default: wb_data_sel = alu_result_i;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (advance && valid_i && halt_i) begin
      state_next = HALTED;
    end
  end

  always_comb begin
    halt_o = (state == HALTED);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wb_data_o      <= '0;
      wb_rd_o        <= '0;
      wb_reg_write_o <= 1'b0;
    end else if (advance) begin
      wb_data_o      <= wb_data_sel;
      wb_rd_o        <= rd_i;
      wb_reg_write_o <= reg_write_next;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic        retire;
  logic [31:0] retire_cnt;

  // HALT is not counted; the counter wraps naturally at 32 bits.
  assign retire = advance && valid_i && !halt_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign retired_o = retire_cnt;
`else
  assign retired_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected outputs are queued when stimulus
// is driven and compared one cycle later after the rising edge.
module tb_mem_wb_stage;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;

  typedef struct {
    logic [NB_DATA-1:0] data;
    logic [NB_REG-1:0]  rd;
    logic               we;
    logic               halt;
    logic [31:0]        cnt;
  } exp_t;

  logic               clock_i = 1'b0;
  logic               reset_i = 1'b0;
  logic               en_pipeline = 1'b0;
  logic               valid_i = 1'b0;
  logic [NB_DATA-1:0] mem_data_i = '0;
  logic [NB_DATA-1:0] alu_result_i = '0;
  logic [NB_DATA-1:0] pc_plus8_i = '0;
  logic [2:0]         wb_signals_i = '0;
  logic [NB_REG-1:0]  rd_i = '0;
  logic               halt_i = 1'b0;
  logic [NB_DATA-1:0] wb_data_o;
  logic [NB_REG-1:0]  wb_rd_o;
  logic               wb_reg_write_o;
  logic               halt_o;
  logic [31:0]        retired_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t m;

  mem_wb_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .en_pipeline(en_pipeline),
    .valid_i(valid_i), .mem_data_i(mem_data_i), .alu_result_i(alu_result_i),
    .pc_plus8_i(pc_plus8_i), .wb_signals_i(wb_signals_i), .rd_i(rd_i),
    .halt_i(halt_i), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .wb_reg_write_o(wb_reg_write_o), .halt_o(halt_o), .retired_o(retired_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.data = '0; m.rd = '0; m.we = 1'b0; m.halt = 1'b0; m.cnt = '0;
    sb.delete();
  endtask

  // Reference behaviour of one rising edge, written from the stage's contract.
  task automatic model_edge(input logic en, input logic v, input logic [31:0] mem,
                            input logic [31:0] alu, input logic [31:0] pc8,
                            input logic [2:0] wb, input logic [4:0] rd, input logic h);
    if (en && !m.halt) begin
      m.data = (wb[1:0] == 2'b01) ? mem : (wb[1:0] == 2'b10) ? pc8 : alu;
      m.rd   = rd;
      m.we   = wb[2] && v && !h && (rd != 5'd0);
      if (v && h) m.halt = 1'b1;
`ifdef MEM_WB_RETIRE_CNT_EN
      else if (v) m.cnt = m.cnt + 32'd1;
`endif
    end
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, wb_data_o, e.data);
      check({tag, "_rd"}, 32'(wb_rd_o), 32'(e.rd));
      check({tag, "_we"}, 32'(wb_reg_write_o), 32'(e.we));
      check({tag, "_halt"}, 32'(halt_o), 32'(e.halt));
      check({tag, "_cnt"}, retired_o, e.cnt);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic en, input logic v,
                               input logic [31:0] mem, input logic [31:0] alu,
                               input logic [31:0] pc8, input logic [2:0] wb,
                               input logic [4:0] rd, input logic h);
    @(negedge clock_i);
    en_pipeline = en; valid_i = v; mem_data_i = mem; alu_result_i = alu;
    pc_plus8_i = pc8; wb_signals_i = wb; rd_i = rd; halt_i = h;
    model_edge(en, v, mem, alu, pc8, wb, rd, h);
    sb.push_back(m);
    @(posedge clock_i);
    #1;
    check_output(tag);
  endtask

  task automatic applyRandom(input string tag, input logic en);
    applyStimulus(tag, en, 1'($urandom), $urandom, $urandom, $urandom,
                  3'($urandom), 5'($urandom), 1'($urandom));
  endtask

  // Reset is asserted between edges and the outputs must clear without a clock.
  task automatic applyReset(input string tag);
    @(negedge clock_i);
    en_pipeline = 1'b0; valid_i = 1'b0; halt_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    check({tag, "_data"}, wb_data_o, 32'd0);
    check({tag, "_rd"}, 32'(wb_rd_o), 32'd0);
    check({tag, "_we"}, 32'(wb_reg_write_o), 32'd0);
    check({tag, "_halt"}, 32'(halt_o), 32'd0);
    check({tag, "_cnt"}, retired_o, 32'd0);
    model_reset();
    #1 reset_i = 1'b1;
  endtask

  initial begin
    model_reset();
    $display("[TB] start");
    applyReset("rst0");

    applyStimulus("load", 1, 1, 32'hDEADBEEF, 32'h1111_1111, 32'h2222_2222, 3'b101, 5'd7, 0);
    applyStimulus("alu00", 1, 1, 32'h3, 32'hA5A5_0001, 32'h4, 3'b100, 5'd9, 0);
    applyStimulus("alu11", 1, 1, 32'h5, 32'h0BAD_F00D, 32'h6, 3'b111, 5'd31, 0);
    applyStimulus("link_r0", 1, 1, 32'h7, 32'h8, 32'h40, 3'b110, 5'd0, 0);
    applyStimulus("no_wr", 1, 1, 32'h9, 32'h1234_5678, 32'hA, 3'b000, 5'd4, 0);
    applyStimulus("pre_stall", 1, 1, 32'hCAFE_0000, 32'h1, 32'h2, 3'b101, 5'd12, 0);
    for (int i = 0; i < 3; i++) applyRandom($sformatf("stall%0d", i), 1'b0);
    applyStimulus("bubble", 1, 0, 32'h77, 32'h88, 32'h99, 3'b101, 5'd3, 0);
    applyStimulus("halt_bubble", 1, 0, 32'h1, 32'h2, 32'h3, 3'b100, 5'd5, 1);
    applyStimulus("post_bubble", 1, 1, 32'h1, 32'h2, 32'h3, 3'b110, 5'd6, 0);

    applyReset("rst1");
    for (int i = 0; i < 5; i++)
      applyStimulus($sformatf("run%0d", i), 1, 1, 32'h100 + i, 32'h200 + i, 32'h300 + i,
                    3'b100, 5'(i + 1), 0);
    applyStimulus("halt", 1, 1, 32'hF0, 32'hF1, 32'hF2, 3'b101, 5'd8, 1);
    check("halt_retired", retired_o, m.cnt);
    for (int i = 0; i < 4; i++) applyRandom($sformatf("frozen%0d", i), 1'($urandom));

    applyReset("rst_halted");
    applyStimulus("resume", 1, 1, 32'h55, 32'h66, 32'h77, 3'b101, 5'd2, 0);

`ifdef MEM_WB_RETIRE_CNT_EN
    @(negedge clock_i);
    en_pipeline = 1'b0;
    force dut.retire_cnt = 32'hFFFF_FFFE;
    #1 release dut.retire_cnt;
    m.cnt = 32'hFFFF_FFFE;
    applyStimulus("near_wrap", 1, 1, 32'h1, 32'h2, 32'h3, 3'b100, 5'd1, 0);
    applyStimulus("wrap", 1, 1, 32'h1, 32'h2, 32'h3, 3'b100, 5'd1, 0);
`else
    check("cnt_absent", retired_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no completion expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 32, the data path width.
REQ-002 The module SHALL have parameter NB_REG, default 5, the register-address width.
REQ-003 clock_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_i  input  1  reset, asynchronous and active-low.
REQ-005 en_pipeline  input  1  pipeline advance enable; low SHALL hold all state.
REQ-006 valid_i  input  1  MEM-stage slot holds a real instruction; 0 means bubble.
REQ-007 mem_data_i  input  NB_DATA  load data from the data-memory interface.
REQ-008 alu_result_i  input  NB_DATA  ALU result forwarded through MEM.
REQ-009 pc_plus8_i  input  NB_DATA  link address for JAL/JALR.
REQ-010 wb_signals_i  input  3  [2]=reg_write, [1:0]=wb_sel (00 ALU, 01 mem, 10 link, 11 ALU).
REQ-011 rd_i  input  NB_REG  destination register.
REQ-012 halt_i  input  1  MEM slot holds the HALT instruction.
REQ-013 wb_data_o  output  NB_DATA  selected write-back data to the register file.
REQ-014 wb_rd_o  output  NB_REG  registered destination.
REQ-015 wb_reg_write_o  output  1  register-file write strobe.
REQ-016 halt_o  output  1  pipeline drained and halted.
REQ-017 retired_o  output  32  retired-instruction count.

Function
REQ-018 The stage SHALL be a one-cycle MEM/WB register: inputs sampled on a rising edge with en_pipeline=1 SHALL appear on the outputs after that edge.
REQ-019 wb_data_o SHALL be a registered selection per wb_sel; code 11 SHALL select alu_result_i.
REQ-020 wb_reg_write_o SHALL be reg_write AND valid_i AND NOT halt_i AND rd_i!=0, registered.
REQ-021 With en_pipeline=0, all registers, including the FSM and counter, SHALL hold their values.
REQ-022 The FSM SHALL have two states: RUN and HALTED.
REQ-023 In RUN, an edge sampling en_pipeline=1, valid_i=1 and halt_i=1 SHALL move the FSM to HALTED.
REQ-024 halt_o SHALL be 1 exactly when the FSM is in HALTED.
REQ-025 HALTED SHALL be exited only by reset.
REQ-026 In HALTED, all registers SHALL freeze regardless of en_pipeline, and wb_reg_write_o SHALL be 0.
REQ-027 halt_i with valid_i=0 SHALL be ignored.
REQ-028 The counter SHALL increment by 1 on each edge in RUN with en_pipeline=1, valid_i=1 and halt_i=0; HALT itself is not counted.
REQ-029 The counter SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 reset_i low SHALL immediately force all of the following, independent of clock_i:
- wb_data_o=0
- wb_rd_o=0
- wb_reg_write_o=0
- halt_o=0
- retired_o=0
- FSM=RUN
REQ-031 Reset asserted mid-operation, including while HALTED, SHALL abandon the current state.
REQ-032 The first edge after reset_i rises SHALL sample inputs normally.

Configuration
REQ-033 With macro MEM_WB_RETIRE_CNT_EN defined, the retire counter SHALL be implemented per REQ-028 and REQ-029.
REQ-034 Without MEM_WB_RETIRE_CNT_EN, no counter flops SHALL exist and retired_o SHALL be constant 0.

Verification
REQ-035 Load data path: valid=1, wb_signals=3'b101, rd=7, mem_data=0xDEADBEEF -> next cycle wb_data_o=0xDEADBEEF, wb_rd_o=7, wb_reg_write_o=1.
REQ-036 Write-back select and r0: wb_sel=10 with pc_plus8=0x40 and rd=0 -> wb_data_o=0x40 and wb_reg_write_o=0.
REQ-037 Stall and bubble: en_pipeline=0 for 3 cycles with changing inputs -> outputs unchanged; valid_i=0 -> wb_reg_write_o=0 and retired_o unchanged.
REQ-038 Halt: 5 valid instructions, then halt_i=1 -> retired_o=5, halt_o=1; later stimulus -> outputs frozen.
REQ-039 Reset mid-halt: drive reset_i low between edges -> all outputs 0 immediately; after release, counting resumes from 0.
REQ-040 Wrap and macro: preload the counter near 0xFFFFFFFF via 2^32-1 retires (or a forced value) -> next retire gives 0; build without MEM_WB_RETIRE_CNT_EN -> retired_o=0 throughout.
